// File: rtl/voter_pkg.sv
// rtl/voter_pkg.sv - shared types, verdict indices and width helper for voter_session
package voter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    DECIDE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int V_PASS = 3;
  localparam int V_TIE  = 2;
  localparam int V_FAIL = 1;

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/voter_session_if.sv
// rtl/voter_session_if.sv - session control, vote and verdict signals of voter_session
interface voter_session_if
  import voter_pkg::*;
#(
  parameter int N_VOTERS = 4
);
  localparam int CW = cnt_width(N_VOTERS);

  logic                start;
  logic [N_VOTERS-1:0] vote_valid;
  logic [N_VOTERS-1:0] vote_yes;
  logic                result_ready;
  logic                busy;
  logic [N_VOTERS-1:0] voted;
  logic [CW-1:0]       yes_cnt;
  logic [CW-1:0]       no_cnt;
  logic                result_valid;
  logic [3:1]          O;
  logic                no_quorum;

  modport master (
    output start, vote_valid, vote_yes, result_ready,
    input  busy, voted, yes_cnt, no_cnt, result_valid, O, no_quorum
  );

  modport slave (
    input  start, vote_valid, vote_yes, result_ready,
    output busy, voted, yes_cnt, no_cnt, result_valid, O, no_quorum
  );
endinterface

// File: rtl/voter_popcount.sv
// rtl/voter_popcount.sv - combinational population count of a strobe vector
module voter_popcount
  import voter_pkg::*;
#(
  parameter int W  = 4,
  parameter int OW = cnt_width(W)
) (
  input  logic [W-1:0]  bits,
  output logic [OW-1:0] cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + OW'(bits[i]);
    end
  end
endmodule

// File: rtl/voter_session.sv
// rtl/voter_session.sv - timed N-voter session with quorum-checked pass/tie/fail verdict
module voter_session
  import voter_pkg::*;
#(
  parameter int N_VOTERS = 4,
  parameter int TIMEOUT  = 16,
  parameter int QUORUM   = N_VOTERS
) (
  input logic             clk,
  input logic             rst_n,
  voter_session_if.slave  bus
);
  localparam int CW = cnt_width(N_VOTERS);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [N_VOTERS-1:0] voted_q, voted_d;
  logic [CW-1:0]       yes_q, yes_d;
  logic [CW-1:0]       no_q, no_d;
  logic [3:1]          o_q, o_d;
  logic                nq_q, nq_d;
  logic                busy_q, busy_d;
  logic                rv_q, rv_d;

  logic [N_VOTERS-1:0] accept_yes, accept_no;
  logic [CW-1:0]       add_yes, add_no;
  logic [CW:0]         total;

  // Only first-time voters are counted; a locked voter's strobe is masked here.
  assign accept_yes = bus.vote_valid & ~voted_q &  bus.vote_yes;
  assign accept_no  = bus.vote_valid & ~voted_q & ~bus.vote_yes;

  voter_popcount #(.W(N_VOTERS), .OW(CW)) u_pop_yes (
    .bits (accept_yes),
    .cnt  (add_yes)
  );

  voter_popcount #(.W(N_VOTERS), .OW(CW)) u_pop_no (
    .bits (accept_no),
    .cnt  (add_no)
  );

  assign total = {1'b0, yes_q} + {1'b0, no_q};

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    voted_d = voted_q;
    yes_d   = yes_q;
    no_d    = no_q;
    o_d     = o_q;
    nq_d    = nq_q;
    busy_d  = busy_q;
    rv_d    = rv_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = OPEN;
          busy_d  = 1'b1;
          timer_d = '0;
          voted_d = '0;
          yes_d   = '0;
          no_d    = '0;
        end
      end
      OPEN: begin
        voted_d = voted_q | bus.vote_valid;
        yes_d   = yes_q + add_yes;
        no_d    = no_q + add_no;
        timer_d = timer_q + TW'(1);
        if ((&voted_d) || (timer_q == T_LAST)) begin
          state_d = DECIDE;
        end
      end
      DECIDE: begin
        state_d = DONE;
        rv_d    = 1'b1;
        o_d     = '0;
        if (total < (CW+1)'(QUORUM)) begin
          nq_d = 1'b1;
        end else begin
          nq_d = 1'b0;
          if (yes_q > no_q)       o_d[V_PASS] = 1'b1;
          else if (yes_q == no_q) o_d[V_TIE]  = 1'b1;
          else                    o_d[V_FAIL] = 1'b1;
        end
      end
      DONE: begin
        if (bus.result_ready) begin
          state_d = IDLE;
          rv_d    = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        rv_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      voted_q <= '0;
      yes_q   <= '0;
      no_q    <= '0;
      o_q     <= '0;
      nq_q    <= 1'b0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      voted_q <= voted_d;
      yes_q   <= yes_d;
      no_q    <= no_d;
      o_q     <= o_d;
      nq_q    <= nq_d;
      busy_q  <= busy_d;
      rv_q    <= rv_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.voted        = voted_q;
  assign bus.yes_cnt      = yes_q;
  assign bus.no_cnt       = no_q;
  assign bus.result_valid = rv_q;
  assign bus.O            = o_q;
  assign bus.no_quorum    = nq_q;
endmodule
